// File: rtl/control_pc.sv
// control_pc: program-counter sequencer for the single-cycle core.
// Fetches over req/ack, holds one execute window, then picks the next PC.
module control_pc #(
  parameter int             W        = 32,
  parameter logic [W-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W-1:0] imem_rdata,
  output logic [W-1:0] instruccion,
  output logic         instr_valid,
  input  logic         salto,
  input  logic         es_jal,
  input  logic         es_jalr,
  input  logic [W-1:0] destino,
  input  logic         stall,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc_mas4,
  output logic         halt,
  output logic         error,
  output logic [W-1:0] retiradas
);

  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_t;

  state_t       state;
  state_t       state_d;
  logic [W-1:0] pc_d;
  logic [W-1:0] instr_d;
  logic [W-1:0] ret_d;
  logic         halt_d;
  logic         error_d;

  logic         es_sys;
  logic         es_branch;
  logic [W-1:0] target;
  logic         misaligned;

  assign pc_mas4     = pc + W'(4);
  assign imem_addr   = pc;
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == EXEC);

  assign es_sys    = (instruccion[6:0] == OP_SYSTEM) &&
                     (instruccion[14:12] == 3'b000);
  assign es_branch = (instruccion[6:0] == OP_BRANCH);

  // Jump kinds in priority order; salto only counts for real branches
  always_comb begin
    target = pc_mas4;
    if (es_jalr) begin
      target = {destino[W-1:1], 1'b0};
    end else if (es_jal) begin
      target = destino;
    end else if (salto && es_branch) begin
      target = destino;
    end
  end

  assign misaligned = |target[1:0];

  always_comb begin
    state_d = state;
    pc_d    = pc;
    instr_d = instruccion;
    ret_d   = retiradas;
    halt_d  = halt;
    error_d = error;
    unique case (state)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          ret_d = retiradas + W'(1);
          if (es_sys) begin
            halt_d  = 1'b1;
            state_d = HALT;
          end else if (misaligned) begin
            halt_d  = 1'b1;
            error_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = target;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instruccion <= '0;
      retiradas   <= '0;
      halt        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instruccion <= instr_d;
      retiradas   <= ret_d;
      halt        <= halt_d;
      error       <= error_d;
    end
  end

endmodule

// File: tb/tb_control_pc.sv
// tb_control_pc: directed + randomized checks of control_pc
// against an instruction-level reference model.
module tb_control_pc;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] BEQ    = 32'h0000_0063;
  localparam logic [31:0] JAL    = 32'h0000_006F;
  localparam logic [31:0] JALR   = 32'h0000_0067;
  localparam logic [31:0] ECALL  = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruccion;
  logic        instr_valid;
  logic        salto = 1'b0;
  logic        es_jal = 1'b0;
  logic        es_jalr = 1'b0;
  logic [31:0] destino = '0;
  logic        stall = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_mas4;
  logic        halt;
  logic        error;
  logic [31:0] retiradas;

  control_pc #(.W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruccion(instruccion), .instr_valid(instr_valid),
    .salto(salto), .es_jal(es_jal), .es_jalr(es_jalr),
    .destino(destino), .stall(stall),
    .pc(pc), .pc_mas4(pc_mas4),
    .halt(halt), .error(error), .retiradas(retiradas)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  bit en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one instruction at a time, either awaiting its
  // fetch or sitting in its execute window, until halted.
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_ret = '0;
  logic [31:0] m_instr = '0;
  bit          m_exec = 1'b0;
  bit          m_halt = 1'b0;
  bit          m_err = 1'b0;

  function automatic bit is_sys(input logic [31:0] i);
    return (i[6:0] == 7'h73) && (i[14:12] == 3'b000);
  endfunction

  function automatic logic [31:0] next_pc(
    input logic [31:0] p, input logic [31:0] i, input logic [31:0] d,
    input logic s, input logic j, input logic jr);
    if (jr) return d & ~32'h1;
    if (j) return d;
    if (s && i[6:0] == 7'h63) return d;
    return p + 32'd4;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= RST_PC; m_ret <= '0; m_instr <= '0;
      m_exec <= 1'b0; m_halt <= 1'b0; m_err <= 1'b0;
    end else if (!m_halt) begin
      if (!m_exec) begin
        if (imem_ack) begin
          m_instr <= imem_rdata;
          m_exec  <= 1'b1;
        end
      end else if (!stall) begin
        m_ret <= m_ret + 32'd1;
        if (is_sys(m_instr)) begin
          m_halt <= 1'b1;
        end else if (next_pc(m_pc, m_instr, destino, salto,
                             es_jal, es_jalr) % 4 != 0) begin
          m_halt <= 1'b1;
          m_err  <= 1'b1;
        end else begin
          m_pc   <= next_pc(m_pc, m_instr, destino, salto, es_jal, es_jalr);
          m_exec <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("imem_req", 32'(imem_req), 32'(!m_halt && !m_exec));
      chk("instr_valid", 32'(instr_valid), 32'(m_exec && !m_halt));
      chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("pc_mas4", pc_mas4, m_pc + 32'd4);
      chk("instruccion", instruccion, m_instr);
      chk("retiradas", retiradas, m_ret);
      chk("halt", 32'(halt), 32'(m_halt));
      chk("error", 32'(error), 32'(m_err));
      if (instr_valid) valid_cnt++;
    end
  end

  task automatic run_instr(
    input logic [31:0] w, input int dly, input int stl,
    input logic s, input logic j, input logic jr,
    input logic [31:0] d, input logic [31:0] exp_addr);
    imem_ack = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < dly; i++) begin
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, exp_addr);
      @(negedge clk);
    end
    chk("fetch_addr", imem_addr, exp_addr);
    imem_ack = 1'b1;
    imem_rdata = w;
    salto = s; es_jal = j; es_jalr = jr; destino = d;
    stall = (stl > 0);
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (stl) @(negedge clk);
    stall = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(input bit lit);
    #1 rst = 1'b1;
    #1;
    if (lit) begin
      chk("rst_pc", pc, RST_PC);
      chk("rst_halt", 32'(halt), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_ret", retiradas, 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    if (lit) chk("rst_req", 32'(imem_req), 32'd1);
  endtask

  task automatic drive_random();
    logic [31:0] w;
    logic [31:0] t;
    int r;
    stall = ($urandom_range(0, 3) == 0);
    imem_ack = ($urandom_range(0, 2) != 0);
    if (!m_exec) begin
      w = $urandom;
      r = $urandom_range(0, 19);
      salto = 1'($urandom_range(0, 1));
      es_jal = 1'b0;
      es_jalr = 1'b0;
      case (r)
        0: w = ECALL;
        1: w = {w[31:15], 3'b000, w[11:7], 7'b1110011};
        2: w = {w[31:15], 3'b010, w[11:7], 7'b1110011};
        3, 4, 5, 6: w[6:0] = 7'b1100011;
        7, 8: begin w[6:0] = 7'b1101111; es_jal = 1'b1; end
        9: begin w[6:0] = 7'b1100111; es_jalr = 1'b1; end
        10: begin w[6:0] = 7'b1100111; es_jal = 1'b1; es_jalr = 1'b1; end
        default: w[6:0] = 7'b0010011;
      endcase
      t = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) destino = t;
      else if (r == 1) destino = 32'hFFFF_FFFC;
      else destino = t & ~32'h3;
      if (es_jalr && $urandom_range(0, 1) == 1) destino = destino | 32'h1;
      imem_rdata = w;
    end else begin
      imem_rdata = $urandom;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int v0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    chk("init_pc", pc, RST_PC);
    chk("init_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0;
    chk("init_req", 32'(imem_req), 32'd1);

    run_instr(ADDI, 0, 0, 0, 0, 0, 32'h0, 32'h100);
    run_instr(ADDI, 0, 0, 0, 0, 0, 32'h0, 32'h104);
    run_instr(ADDI, 0, 0, 0, 0, 0, 32'h0, 32'h108);
    run_instr(ADDI, 0, 0, 0, 0, 0, 32'h0, 32'h10C);
    chk("ret_after_4", retiradas, 32'd4);
    run_instr(ADDI, 3, 0, 0, 0, 0, 32'h0, 32'h110);
    run_instr(JAL, 0, 0, 0, 1, 0, 32'h20, 32'h114);
    run_instr(BEQ, 0, 0, 1, 0, 0, 32'h80, 32'h20);
    run_instr(JAL, 0, 0, 0, 1, 0, 32'h20, 32'h80);
    run_instr(BEQ, 0, 0, 0, 0, 0, 32'h80, 32'h20);
    run_instr(ADDI, 0, 0, 1, 0, 0, 32'h80, 32'h24);
    run_instr(JALR, 0, 0, 0, 0, 1, 32'h41, 32'h28);
    v0 = valid_cnt;
    run_instr(ADDI, 0, 5, 0, 0, 0, 32'h0, 32'h40);
    chk("stall_valid_cycles", 32'(valid_cnt - v0), 32'd6);
    chk("ret_after_stall", retiradas, 32'd12);
    run_instr(JAL, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h44);
    chk("wrap_mas4", pc_mas4, 32'h0);
    run_instr(ADDI, 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC);
    run_instr(JAL, 0, 0, 0, 1, 0, 32'h42, 32'h0);
    chk("mis_halt", 32'(halt), 32'd1);
    chk("mis_error", 32'(error), 32'd1);
    chk("mis_pc", pc, 32'h0);
    chk("mis_req", 32'(imem_req), 32'd0);
    chk("mis_ret", retiradas, 32'd15);
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    chk("frozen_pc", pc, 32'h0);
    chk("frozen_ret", retiradas, 32'd15);
    chk("frozen_req", 32'(imem_req), 32'd0);

    do_reset(1'b1);
    run_instr(ECALL, 0, 0, 0, 0, 0, 32'h0, 32'h100);
    chk("ecall_halt", 32'(halt), 32'd1);
    chk("ecall_error", 32'(error), 32'd0);
    chk("ecall_ret", retiradas, 32'd1);
    chk("ecall_pc", pc, 32'h100);
    do_reset(1'b1);
    chk("restart_addr", imem_addr, 32'h100);

    for (int c = 0; c < 4000; c++) begin
      if ((m_halt && $urandom_range(0, 5) == 0) ||
          $urandom_range(0, 399) == 0)
        do_reset(1'b0);
      else
        drive_random();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
